// File: rtl/dct_mac_sequencer.sv
// 8-point 1-D DCT sequencer: loads 8 samples, then time-multiplexes one external
// signed multiplier (one product per clock) to emit X[0..7] over a valid/ready stream.
module dct_mac_sequencer #(
    parameter int DATA_W = 8,
    parameter int PROD_W = 16,
    parameter int N      = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_data,
    output logic                     o_ready,
    output logic                     o_valid,
    output logic signed [PROD_W-1:0] o_coef,
    output logic [2:0]               o_index,
    input  logic                     i_ready,
    output logic signed [DATA_W-1:0] o_mult_a,
    output logic signed [DATA_W-1:0] o_mult_b,
    input  logic signed [PROD_W-1:0] i_mult_p,
    output logic                     o_busy
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Q1.6 cosine rows, n=0 in the most significant byte.
    function automatic logic [63:0] coef_row(input logic [2:0] k);
        case (k)
            3'd0:    coef_row = {8{8'sd23}};
            3'd1:    coef_row = {8'sd31, 8'sd27, 8'sd18, 8'sd6, -8'sd6, -8'sd18, -8'sd27, -8'sd31};
            3'd2:    coef_row = {8'sd30, 8'sd12, -8'sd12, -8'sd30, -8'sd30, -8'sd12, 8'sd12, 8'sd30};
            3'd3:    coef_row = {8'sd27, -8'sd6, -8'sd31, -8'sd18, 8'sd18, 8'sd31, 8'sd6, -8'sd27};
            3'd4:    coef_row = {8'sd23, -8'sd23, -8'sd23, 8'sd23, 8'sd23, -8'sd23, -8'sd23, 8'sd23};
            3'd5:    coef_row = {8'sd18, -8'sd31, 8'sd6, 8'sd27, -8'sd27, -8'sd6, 8'sd31, -8'sd18};
            3'd6:    coef_row = {8'sd12, -8'sd30, 8'sd30, -8'sd12, -8'sd12, 8'sd30, -8'sd30, 8'sd12};
            3'd7:    coef_row = {8'sd6, -8'sd18, 8'sd27, -8'sd31, 8'sd31, -8'sd27, 8'sd18, -8'sd6};
            default: coef_row = 64'd0;
        endcase
    endfunction

    state_t                     state_r;
    logic [2:0]                 count_r;
    logic [2:0]                 k_r;
    logic [2:0]                 n_r;
    logic signed [PROD_W-1:0]   acc_r;
    logic signed [DATA_W-1:0]   x_r [N];
    logic [63:0]                row_s;
    logic signed [PROD_W-1:0]   sum_s;

    // Multiplier operands are only live during MAC; ~n_r selects byte n from the MSB side.
    always_comb begin
        row_s    = coef_row(k_r);
        o_mult_a = '0;
        o_mult_b = '0;
        if (state_r == MAC) begin
            o_mult_a = x_r[n_r];
            o_mult_b = row_s[{~n_r, 3'b000} +: 8];
        end else begin
            o_mult_a = '0;
            o_mult_b = '0;
        end
    end

    // Running sum restarts on n=0, wraps modulo 2^PROD_W.
    always_comb begin
        if (n_r == 3'd0) begin
            sum_s = i_mult_p;
        end else begin
            sum_s = acc_r + i_mult_p;
        end
    end

    // Sequencer FSM with registered handshake and result outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= LOAD;
            count_r <= 3'd0;
            k_r     <= 3'd0;
            n_r     <= 3'd0;
            acc_r   <= '0;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_coef  <= '0;
            o_index <= 3'd0;
            o_busy  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                x_r[i] <= '0;
            end
        end else begin
            case (state_r)
                LOAD: begin
                    if (i_valid && o_ready) begin
                        x_r[count_r] <= i_data;
                        if (count_r == 3'd7) begin
                            count_r <= 3'd0;
                            k_r     <= 3'd0;
                            n_r     <= 3'd0;
                            o_ready <= 1'b0;
                            o_busy  <= 1'b1;
                            state_r <= MAC;
                        end else begin
                            count_r <= count_r + 3'd1;
                        end
                    end
                end
                MAC: begin
                    acc_r <= sum_s;
                    n_r   <= n_r + 3'd1;
                    if (n_r == 3'd7) begin
                        o_coef  <= sum_s;
                        o_index <= k_r;
                        o_valid <= 1'b1;
                        state_r <= OUT;
                    end
                end
                OUT: begin
                    if (o_valid && i_ready) begin
                        o_valid <= 1'b0;
                        n_r     <= 3'd0;
                        if (k_r == 3'd7) begin
                            k_r     <= 3'd0;
                            o_ready <= 1'b1;
                            o_busy  <= 1'b0;
                            state_r <= LOAD;
                        end else begin
                            k_r     <= k_r + 3'd1;
                            state_r <= MAC;
                        end
                    end
                end
                default: begin
                    state_r <= LOAD;
                    o_ready <= 1'b1;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dct_mac_sequencer.sv
// Directed bench for dct_mac_sequencer: real-valued DCT reference model, a scoreboard
// of expected coefficients and one negedge compare process.
module tb_dct_mac_sequencer;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b1;
    logic               i_valid = 1'b0;
    logic signed [7:0]  i_data = 8'sd0;
    logic               o_ready;
    logic               o_valid;
    logic signed [15:0] o_coef;
    logic [2:0]         o_index;
    logic               i_ready = 1'b1;
    logic signed [7:0]  o_mult_a;
    logic signed [7:0]  o_mult_b;
    logic signed [15:0] i_mult_p;
    logic               o_busy;
    logic signed [15:0] prod_full;

    dct_mac_sequencer #(.DATA_W(8), .PROD_W(16), .N(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
        .o_ready(o_ready), .o_valid(o_valid), .o_coef(o_coef), .o_index(o_index),
        .i_ready(i_ready), .o_mult_a(o_mult_a), .o_mult_b(o_mult_b),
        .i_mult_p(i_mult_p), .o_busy(o_busy)
    );

    // External multiplier: full product, floor-shifted by 6.
    assign prod_full = o_mult_a * o_mult_b;
    assign i_mult_p  = prod_full >>> 6;

    always #5 i_clk = ~i_clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int accept_cyc = 0;
    bit first_pending = 1'b0;
    int cmat [8][8];
    int blk [8];
    int model_x [8];
    int sb_coef [$];
    int sb_idx  [$];

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: C[k][n] from the cosine formula, round half away from zero.
    task automatic build_rom();
        real a, v, r;
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 8; n++) begin
                a = (k == 0) ? $sqrt(1.0 / 8.0) : 0.5;
                v = 64.0 * a * $cos((2.0 * n + 1.0) * k * 3.14159265358979 / 16.0);
                r = (v >= 0.0) ? $floor(v + 0.5) : -$floor(-v + 0.5);
                cmat[k][n] = int'(r);
            end
        end
    endtask

    // X[k] = sum_n floor(x[n]*C[k][n]/64), wrapped to 16 bits.
    task automatic compute_model();
        int s;
        logic signed [15:0] w;
        for (int k = 0; k < 8; k++) begin
            s = 0;
            for (int n = 0; n < 8; n++) begin
                s = s + ((blk[n] * cmat[k][n]) >>> 6);
            end
            w = s[15:0];
            model_x[k] = int'(w);
        end
    endtask

    task automatic feed_block();
        bit got, rdy;
        compute_model();
        for (int i = 0; i < 8; i++) begin
            i_valid = 1'b1;
            i_data  = blk[i][7:0];
            got = 1'b0;
            for (int t = 0; t < 200 && !got; t++) begin
                @(negedge i_clk);
                rdy = o_ready;
                @(posedge i_clk);
                #1;
                if (rdy) got = 1'b1;
            end
            if (!got) chk("feed_timeout", 0, 1);
        end
        i_valid = 1'b0;
        accept_cyc = cyc;
        first_pending = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sb_coef.push_back(model_x[k]);
            sb_idx.push_back(k);
        end
    endtask

    task automatic wait_drain(input bit check72);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 600 && !done; t++) begin
            @(posedge i_clk);
            #1;
            if (sb_coef.size() == 0) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 0, 1);
        if (check72) chk("mac_to_last_handshake_cycles", cyc - accept_cyc, 72);
        chk("ready_after_block", int'(o_ready), 1);
        chk("valid_after_block", int'(o_valid), 0);
        chk("busy_after_block", int'(o_busy), 0);
    endtask

    // Compare process: scoreboard on handshake, latency, hold stability, ready/busy rules.
    logic               hold_pend = 1'b0;
    logic signed [15:0] hold_coef;
    logic [2:0]         hold_idx;
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (hold_pend) begin
                chk("hold_valid", int'(o_valid), 1);
                chk("hold_coef", int'(o_coef), int'(hold_coef));
                chk("hold_index", int'(o_index), int'(hold_idx));
            end
            hold_pend = o_valid && !i_ready;
            hold_coef = o_coef;
            hold_idx  = o_index;
            if (first_pending && o_valid) begin
                chk("first_valid_latency", cyc - accept_cyc, 8);
                first_pending = 1'b0;
            end
            if (o_valid) begin
                chk("ready_low_while_valid", int'(o_ready), 0);
                chk("busy_while_valid", int'(o_busy), 1);
            end
            if (o_valid && i_ready) begin
                if (sb_coef.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    chk("coef", int'(o_coef), sb_coef.pop_front());
                    chk("index", int'(o_index), sb_idx.pop_front());
                end
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    initial begin
        build_rom();
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_ready", int'(o_ready), 1);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_coef", int'(o_coef), 0);
        chk("rst_index", int'(o_index), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_mult_b", int'(o_mult_b), 0);
        i_rst = 1'b0;

        // Hand-computed pins on the reference model.
        chk("model_c00", cmat[0][0], 23);
        chk("model_c10", cmat[1][0], 31);
        chk("model_c17", cmat[1][7], -31);
        chk("model_c21", cmat[2][1], 12);
        chk("model_c53", cmat[5][3], 27);
        chk("model_c75", cmat[7][5], -27);
        foreach (blk[i]) blk[i] = 64;
        compute_model();
        chk("model_dc_x0", model_x[0], 184);
        chk("model_dc_x1", model_x[1], 0);
        foreach (blk[i]) blk[i] = (i == 0) ? 127 : 0;
        compute_model();
        chk("model_imp_x0", model_x[0], 45);
        chk("model_imp_x1", model_x[1], 61);
        chk("model_imp_x2", model_x[2], 59);
        chk("model_imp_x7", model_x[7], 11);

        // Zeros block, with the 72-cycle budget.
        foreach (blk[i]) blk[i] = 0;
        feed_block();
        wait_drain(1'b1);

        // DC block: operand B is 23 across the first MAC pass.
        foreach (blk[i]) blk[i] = 64;
        feed_block();
        for (int i = 0; i < 8; i++) begin
            chk("dc_mult_b", int'(o_mult_b), 23);
            chk("dc_mult_a", int'(o_mult_a), 64);
            @(posedge i_clk);
            #1;
        end
        wait_drain(1'b0);

        foreach (blk[i]) blk[i] = -64;
        feed_block();
        wait_drain(1'b0);

        foreach (blk[i]) blk[i] = (i == 0) ? 127 : 0;
        feed_block();
        wait_drain(1'b0);

        // Backpressure at index 3.
        blk = '{10, -20, 30, -40, 50, -60, 70, -80};
        feed_block();
        begin
            bit seen;
            seen = 1'b0;
            for (int t = 0; t < 300 && !seen; t++) begin
                @(posedge i_clk);
                #1;
                if (!o_valid && o_index == 3'd2) seen = 1'b1;
            end
            if (!seen) chk("bp_reach_k3", 0, 1);
            i_ready = 1'b0;
            seen = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge i_clk);
                if (o_valid) seen = 1'b1;
            end
            if (!seen) chk("bp_valid_timeout", 0, 1);
            for (int i = 0; i < 5; i++) begin
                @(negedge i_clk);
                chk("bp_valid", int'(o_valid), 1);
                chk("bp_index", int'(o_index), 3);
                chk("bp_ready", int'(o_ready), 0);
                chk("bp_mult_b", int'(o_mult_b), 0);
            end
            @(posedge i_clk);
            #1;
            i_ready = 1'b1;
        end
        wait_drain(1'b0);

        // Async reset during MAC of k=2, then a fresh DC block.
        foreach (blk[i]) blk[i] = 64;
        feed_block();
        begin
            bit seen;
            seen = 1'b0;
            for (int t = 0; t < 300 && !seen; t++) begin
                @(posedge i_clk);
                #1;
                if (!o_valid && o_index == 3'd1) seen = 1'b1;
            end
            if (!seen) chk("rst_reach_k2", 0, 1);
            repeat (3) @(posedge i_clk);
            #2;
            i_rst = 1'b1;
            #1;
            chk("arst_ready", int'(o_ready), 1);
            chk("arst_valid", int'(o_valid), 0);
            chk("arst_coef", int'(o_coef), 0);
            chk("arst_index", int'(o_index), 0);
            chk("arst_busy", int'(o_busy), 0);
            chk("arst_mult_a", int'(o_mult_a), 0);
            sb_coef.delete();
            sb_idx.delete();
            first_pending = 1'b0;
            @(posedge i_clk);
            #2;
            i_rst = 1'b0;
        end
        feed_block();
        wait_drain(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
